reg_cpu_master: RTL and testbench
=================================

REG_CPU_MASTER -- requirements
Module: reg_cpu_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, meaning the maximum number of ACCESS cycles to wait for wack/rdv (legal range 2..1023).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port cmd_valid, input, 1 bit: a command is offered.
REQ-005 SHALL have port cmd_ready, output, 1 bit: the command is accepted on this edge.
REQ-006 SHALL have port cmd_write, input, 1 bit: 1 = write, 0 = read.
REQ-007 SHALL have port cmd_addr, input, [31:2]: word address.
REQ-008 SHALL have port cmd_wdata, input, 32 bits: write data.
REQ-009 SHALL have port rsp_valid, output, 1 bit: a response is available.
REQ-010 SHALL have port rsp_ready, input, 1 bit: the consumer takes the response.
REQ-011 SHALL have port rsp_rdata, output, 32 bits: read data; 0 for writes and timeouts.
REQ-012 SHALL have port rsp_err, output, 1 bit: the transaction timed out.
REQ-013 SHALL have port reg_cpu_cs, output, 1 bit: bus chip select.
REQ-014 SHALL have port reg_cpu_addr, output, [31:2]: bus address.
REQ-015 SHALL have port reg_cpu_data_wr, output, 32 bits: bus write data.
REQ-016 SHALL have port reg_cpu_we, output, 1 bit: bus write strobe.
REQ-017 SHALL have port reg_cpu_re, output, 1 bit: bus read strobe.
REQ-018 SHALL have port reg_cpu_wack, input, 1 bit: write acknowledge from the responder.
REQ-019 SHALL have port reg_cpu_rdv, input, 1 bit: read data valid from the responder.
REQ-020 SHALL have port reg_cpu_data_rd, input, 32 bits: read data from the responder.

Function
REQ-021 SHALL implement the FSM states IDLE, ACCESS and RESP, with transitions IDLE->ACCESS on cmd_valid&&cmd_ready, ACCESS->RESP on ack or timeout, and RESP->IDLE on rsp_valid&&rsp_ready.
REQ-022 SHALL drive cmd_ready = (state==IDLE) combinationally; cmd_valid is sampled only in IDLE.
REQ-023 SHALL register cmd_write/cmd_addr/cmd_wdata at acceptance and hold reg_cpu_addr/reg_cpu_data_wr stable for the entire ACCESS state.
REQ-024 SHALL assert reg_cpu_cs plus reg_cpu_we (write) or reg_cpu_re (read) from the first cycle after acceptance, registered, only while in ACCESS; we and re are never high together.
REQ-025 SHALL treat the ack as reg_cpu_wack for writes and reg_cpu_rdv for reads, sampled at each edge while in ACCESS; the other ack and any ack seen outside ACCESS SHALL be ignored.
REQ-026 SHALL, on an ack edge: drop cs/we/re on that edge, capture reg_cpu_data_rd into rsp_rdata for reads (0 for writes), clear rsp_err and enter RESP.
REQ-027 SHALL count the ACCESS cycles with an ack-low sample; if TIMEOUT such cycles elapse without an ack, SHALL drop the strobes, set rsp_rdata=0 and rsp_err=1, and enter RESP.
REQ-028 SHALL, when the ack arrives on the same edge as the timeout limit, treat the transaction as a success (the ack has priority).
REQ-029 SHALL hold rsp_valid=1 with rsp_rdata/rsp_err stable throughout RESP until rsp_ready; it returns to IDLE on the rsp_ready edge.
REQ-030 SHALL keep the strobes low for at least 2 consecutive cycles between transactions (RESP plus IDLE), so the responder sees a fresh re rising edge and any stale registered wack/rdv clears.
REQ-031 SHALL give a best-case latency, against a one-cycle-registered responder, of accept edge T -> strobe high T+1..T+2 -> rsp_valid high from T+3.
REQ-032 SHALL reset the timeout counter on every entry into ACCESS.
REQ-033 SHALL have at most one outstanding transaction; there is no pipelining.

Reset
REQ-034 SHALL, while rst=1 at an edge, go to IDLE and drive reg_cpu_cs/we/re=0, reg_cpu_addr=0, reg_cpu_data_wr=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, timeout counter=0; cmd_ready becomes 1 after the reset is released.
REQ-035 SHALL, on reset mid-ACCESS or mid-RESP, abandon the transaction with no response and deassert the strobes on that same edge.

Structure
REQ-036 SHALL place the state enum (IDLE/ACCESS/RESP) and the default TIMEOUT constant in shared package reg_cpu_pkg, reused by the bench driver and monitor.
REQ-037 SHALL be a single module with no sub-module; the timeout counter is inline with width $clog2(TIMEOUT+1).

Verification
REQ-038 SHALL cover a write to addr 0x0 with data 0x1ABC against the image pipe register responder: cs&we high for 2 cycles, rsp_valid at T+3 with rsp_err=0 and rsp_rdata=0; a follow-up read of 0x0 returns 0x1ABC.
REQ-039 SHALL cover back-to-back reads of 0x1 with cmd_valid held high: re is low for at least 2 cycles between them, and both return the last written reg_2 value.
REQ-040 SHALL cover a tied-off responder (wack=rdv=0) with TIMEOUT=4: the strobe is high for exactly 4 cycles, then rsp_err=1 and rsp_rdata=0.
REQ-041 SHALL cover rsp_ready held low for 10 cycles: rsp_valid, rsp_rdata and rsp_err stay stable, cmd_ready stays 0, and no bus activity occurs.
REQ-042 SHALL cover rst pulsed during ACCESS: the strobes are 0 on the next edge, no rsp_valid is produced, and a subsequent write completes normally.
REQ-043 SHALL cover an ack arriving exactly at the TIMEOUT limit: rsp_err=0.

Source files
------------

// File: rtl/reg_cpu_pkg.sv
// Shared definitions for the register-bus master and its bench:
// the controller state encoding and the default ack timeout.
package reg_cpu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/reg_cpu_master.sv
// Single-outstanding command/response master for a simple cs/we/re register bus.
// Each transaction waits for wack or rdv, or ends with an error after TIMEOUT ack-low cycles.
module reg_cpu_master
    import reg_cpu_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:2] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        reg_cpu_cs,
    output logic [31:2] reg_cpu_addr,
    output logic [31:0] reg_cpu_data_wr,
    output logic        reg_cpu_we,
    output logic        reg_cpu_re,
    input  logic        reg_cpu_wack,
    input  logic        reg_cpu_rdv,
    input  logic [31:0] reg_cpu_data_rd
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic          write_q, write_d;
    logic [31:2]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          cs_q, cs_d;
    logic          we_q, we_d;
    logic          re_q, re_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ack;

    // Only the ack that matches the direction of the current access counts.
    assign ack = write_q ? reg_cpu_wack : reg_cpu_rdv;

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cs_d    = cs_q;
        we_d    = we_q;
        re_d    = re_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = ACCESS;
                    write_d = cmd_write;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    cs_d    = 1'b1;
                    we_d    = cmd_write;
                    re_d    = !cmd_write;
                    cnt_d   = '0;
                end
            end
            ACCESS: begin
                // An ack on the limit edge still wins over the timeout.
                if (ack) begin
                    state_d = RESP;
                    cs_d    = 1'b0;
                    we_d    = 1'b0;
                    re_d    = 1'b0;
                    rdata_d = write_q ? 32'd0 : reg_cpu_data_rd;
                    err_d   = 1'b0;
                end else if (cnt_q == LAST_WAIT) begin
                    state_d = RESP;
                    cs_d    = 1'b0;
                    we_d    = 1'b0;
                    re_d    = 1'b0;
                    rdata_d = 32'd0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cs_d    = 1'b0;
                we_d    = 1'b0;
                re_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cs_q    <= 1'b0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cs_q    <= cs_d;
            we_q    <= we_d;
            re_q    <= re_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cmd_ready       = (state_q == IDLE);
    assign rsp_valid       = (state_q == RESP);
    assign rsp_rdata       = rdata_q;
    assign rsp_err         = err_q;
    assign reg_cpu_cs      = cs_q;
    assign reg_cpu_we      = we_q;
    assign reg_cpu_re      = re_q;
    assign reg_cpu_addr    = addr_q;
    assign reg_cpu_data_wr = wdata_q;

endmodule

// File: tb/tb_reg_cpu_master.sv
// Directed bench for reg_cpu_master with a registered register-file responder
// whose ack latency can be stretched or disabled.
module tb_reg_cpu_master;
    import reg_cpu_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:2] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        reg_cpu_cs, reg_cpu_we, reg_cpu_re;
    logic [31:2] reg_cpu_addr;
    logic [31:0] reg_cpu_data_wr;
    logic        reg_cpu_wack, reg_cpu_rdv;
    logic [31:0] reg_cpu_data_rd;

    always #5 clk = ~clk;

    reg_cpu_master #(.TIMEOUT(TO)) dut (
        .clk             (clk),
        .rst             (rst),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_write       (cmd_write),
        .cmd_addr        (cmd_addr),
        .cmd_wdata       (cmd_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_rdata       (rsp_rdata),
        .rsp_err         (rsp_err),
        .reg_cpu_cs      (reg_cpu_cs),
        .reg_cpu_addr    (reg_cpu_addr),
        .reg_cpu_data_wr (reg_cpu_data_wr),
        .reg_cpu_we      (reg_cpu_we),
        .reg_cpu_re      (reg_cpu_re),
        .reg_cpu_wack    (reg_cpu_wack),
        .reg_cpu_rdv     (reg_cpu_rdv),
        .reg_cpu_data_rd (reg_cpu_data_rd)
    );

    // Responder: register file with registered acks, delayed by resp_lat strobe edges.
    logic        resp_en;
    int          resp_lat;
    int          hi_cnt;
    logic [31:0] mem [16];

    always @(posedge clk) begin
        if (rst) begin
            hi_cnt          <= 0;
            reg_cpu_wack    <= 1'b0;
            reg_cpu_rdv     <= 1'b0;
            reg_cpu_data_rd <= '0;
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else begin
            hi_cnt          <= reg_cpu_cs ? hi_cnt + 1 : 0;
            reg_cpu_wack    <= resp_en && reg_cpu_cs && reg_cpu_we && (hi_cnt + 1 >= resp_lat);
            reg_cpu_rdv     <= resp_en && reg_cpu_cs && reg_cpu_re && (hi_cnt + 1 >= resp_lat);
            reg_cpu_data_rd <= mem[reg_cpu_addr[5:2]];
            if (reg_cpu_cs && reg_cpu_we) mem[reg_cpu_addr[5:2]] <= reg_cpu_data_wr;
        end
    end

    // Bus monitor: length of the last strobe-low gap and any we/re overlap.
    int low_run  = 0;
    int last_gap = 0;
    int both_cnt = 0;

    always @(negedge clk) begin
        if (reg_cpu_cs) begin
            if (low_run > 0) last_gap <= low_run;
            low_run <= 0;
        end else begin
            low_run <= low_run + 1;
        end
        if (reg_cpu_we && reg_cpu_re) both_cnt <= both_cnt + 1;
    end

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [16];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_txn(input bit wr, input logic [31:2] addr, input logic [31:0] wd,
                           input bit exp_err, input bit keep_valid, input int hold,
                           output int strobe_n, output int lat_n);
        exp_t        e;
        bit          seen;
        bit          stable;
        logic [31:0] r0;
        logic        e0;
        e.rdata = (wr || exp_err) ? 32'd0 : model[addr[5:2]];
        e.err   = exp_err;
        if (wr) model[addr[5:2]] = wd;
        sb.push_back(e);

        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (cmd_ready) seen = 1'b1;
            else @(negedge clk);
        end
        check("cmd_accepted", {31'd0, seen}, 32'd1);
        @(posedge clk);
        #1;
        if (!keep_valid) cmd_valid = 1'b0;

        strobe_n = 0;
        lat_n    = 0;
        seen     = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            lat_n++;
            if (rsp_valid) seen = 1'b1;
            else if (reg_cpu_cs && (wr ? reg_cpu_we : reg_cpu_re)) strobe_n++;
        end
        check("rsp_valid_seen", {31'd0, seen}, 32'd1);

        r0 = rsp_rdata;
        e0 = rsp_err;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_rdata !== r0 || rsp_err !== e0 || cmd_ready ||
                reg_cpu_cs || reg_cpu_we || reg_cpu_re) stable = 1'b0;
        end
        if (hold > 0) check("rsp_hold_stable", {31'd0, stable}, 32'd1);

        rsp_ready = 1'b1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        end
        $display("txn %s addr=%0h wdata=%0h -> rdata=%0h err=%0b strobe=%0d lat=%0d",
                 wr ? "WR" : "RD", addr, wd, rsp_rdata, rsp_err, strobe_n, lat_n);
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    int  s, l;
    bit  quiet;

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        resp_en   = 1'b1;
        resp_lat  = 1;
        for (int i = 0; i < 16; i++) model[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_cs", {31'd0, reg_cpu_cs}, 32'd0);
        check("rst_we_re", {30'd0, reg_cpu_we, reg_cpu_re}, 32'd0);
        check("rst_addr", {2'd0, reg_cpu_addr}, 32'd0);
        check("rst_data_wr", reg_cpu_data_wr, 32'd0);
        check("rst_rsp", {rsp_rdata[30:0] | {30'd0, rsp_err}, rsp_valid}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("cmd_ready_after_rst", {31'd0, cmd_ready}, 32'd1);

        // Write then read back through a one-cycle responder.
        run_txn(1'b1, 30'h0, 32'h1ABC, 1'b0, 1'b0, 0, s, l);
        check("wr_strobe_cycles", s, 32'd2);
        check("wr_latency", l, 32'd3);
        run_txn(1'b0, 30'h0, 32'h0, 1'b0, 1'b0, 0, s, l);
        check("rd_strobe_cycles", s, 32'd2);
        check("rd_latency", l, 32'd3);

        // Back-to-back reads with cmd_valid held high.
        run_txn(1'b1, 30'h1, 32'hC0DE_0002, 1'b0, 1'b0, 0, s, l);
        run_txn(1'b0, 30'h1, 32'h0, 1'b0, 1'b1, 0, s, l);
        run_txn(1'b0, 30'h1, 32'h0, 1'b0, 1'b0, 0, s, l);
        check("b2b_gap_ge2", {31'd0, last_gap >= 2}, 32'd1);

        // Tied-off responder runs into the timeout.
        resp_en = 1'b0;
        run_txn(1'b0, 30'h2, 32'h0, 1'b1, 1'b0, 0, s, l);
        check("to_strobe_cycles", s, TO);
        check("to_latency", l, TO + 1);
        resp_en = 1'b1;

        // Consumer stalls the response for 10 cycles.
        run_txn(1'b0, 30'h0, 32'h0, 1'b0, 1'b0, 10, s, l);

        // Ack landing on the limit edge succeeds; one edge later is a timeout.
        resp_lat = TO - 1;
        run_txn(1'b0, 30'h1, 32'h0, 1'b0, 1'b0, 0, s, l);
        check("ack_at_limit_strobe", s, TO);
        resp_lat = TO;
        run_txn(1'b0, 30'h0, 32'h0, 1'b1, 1'b0, 0, s, l);
        check("ack_after_limit_strobe", s, TO);
        resp_lat = 1;

        // Reset pulsed in the middle of an access.
        resp_en = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 30'h1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("mid_access_cs", {30'd0, reg_cpu_cs, reg_cpu_re}, 32'd3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_access_strobes", {29'd0, reg_cpu_cs, reg_cpu_we, reg_cpu_re}, 32'd0);
        for (int i = 0; i < 16; i++) model[i] = '0;
        quiet = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid || reg_cpu_cs) quiet = 1'b0;
        end
        check("rst_no_response", {31'd0, quiet}, 32'd1);
        $display("txn RST during read access -> no response");
        resp_en = 1'b1;
        run_txn(1'b1, 30'h3, 32'h5A5A, 1'b0, 1'b0, 0, s, l);
        check("post_rst_wr_latency", l, 32'd3);
        run_txn(1'b0, 30'h3, 32'h0, 1'b0, 1'b0, 0, s, l);

        check("we_re_never_both", both_cnt, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "bench time limit");
    end

endmodule
